// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU compare/select path.
//   FOP_*       : op encodings on the 3-bit op field (5..7 reserved)
//   fcmp_cls_t  : per-operand-pair classification bundle produced by
//                 fcmp_classify and optionally registered as a pipeline stage
//   canon_nan() : canonical quiet NaN for a given exponent/mantissa width,
//                 returned in an FP_MAX_W-wide word (caller slices to W)
package fpu_pkg;

  localparam logic [2:0] FOP_FEQ  = 3'd0;
  localparam logic [2:0] FOP_FLT  = 3'd1;
  localparam logic [2:0] FOP_FLE  = 3'd2;
  localparam logic [2:0] FOP_FMIN = 3'd3;
  localparam logic [2:0] FOP_FMAX = 3'd4;

  localparam int FP_MAX_W = 64;

  typedef struct packed {
    logic sign_a;
    logic sign_xor;
    logic exp_eq;
    logic exp_lt;
    logic man_le;
    logic man_eq;
    logic both_zero;
    logic nan_a;
    logic nan_b;
    logic snan_a;
    logic snan_b;
  } fcmp_cls_t;

  // +0 sign, all-ones exponent, mantissa MSB only.
  function automatic logic [FP_MAX_W-1:0] canon_nan(input int exp_w, input int man_w);
    logic [FP_MAX_W-1:0] e_ones;
    e_ones = (FP_MAX_W'(1) << exp_w) - FP_MAX_W'(1);
    return (e_ones << man_w) | (FP_MAX_W'(1) << (man_w - 1));
  endfunction

endpackage

// File: rtl/fcmp_pipe_if.sv
// Request/response bundle between the FPU issue logic and fcmp_pipe.
//   master : en, op, a, b, tag_in, stall out; c, ready, tag_out, nv in
//   slave  : mirror of master (used by fcmp_pipe)
interface fcmp_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 5
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic             en;
  logic [2:0]       op;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [TAG_W-1:0] tag_in;
  logic             stall;
  logic [W-1:0]     c;
  logic             ready;
  logic [TAG_W-1:0] tag_out;
  logic             nv;

  modport master (
    output en, op, a, b, tag_in, stall,
    input  c, ready, tag_out, nv
  );

  modport slave (
    input  en, op, a, b, tag_in, stall,
    output c, ready, tag_out, nv
  );

endinterface

// File: rtl/fcmp_classify.sv
// Combinational operand classification for the compare/select unit.
//   a, b : operands, {sign, exponent[EXP_W], mantissa[MAN_W]}
//   cls  : sign/exponent/mantissa relations, zero and NaN flags
// A zero exponent field means zero (denormals flush). NaN flags are only
// built when NAN_EN != 0; otherwise they are constant 0.
module fcmp_classify
  import fpu_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int NAN_EN = 1,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output fcmp_cls_t    cls
);

  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W-1:0] man_a, man_b;
  logic             nan_a, nan_b, snan_a, snan_b;

  assign exp_a = a[W-2:MAN_W];
  assign exp_b = b[W-2:MAN_W];
  assign man_a = a[MAN_W-1:0];
  assign man_b = b[MAN_W-1:0];

  generate
    if (NAN_EN != 0) begin : g_nan
      assign nan_a  = (&exp_a) & (|man_a);
      assign nan_b  = (&exp_b) & (|man_b);
      assign snan_a = nan_a & ~man_a[MAN_W-1];
      assign snan_b = nan_b & ~man_b[MAN_W-1];
    end else begin : g_no_nan
      assign nan_a  = 1'b0;
      assign nan_b  = 1'b0;
      assign snan_a = 1'b0;
      assign snan_b = 1'b0;
    end
  endgenerate

  always_comb begin
    cls           = '0;
    cls.sign_a    = a[W-1];
    cls.sign_xor  = a[W-1] ^ b[W-1];
    cls.exp_eq    = (exp_a == exp_b);
    cls.exp_lt    = (exp_a < exp_b);
    cls.man_le    = (man_a <= man_b);
    cls.man_eq    = (man_a == man_b);
    cls.both_zero = (exp_a == '0) && (exp_b == '0);
    cls.nan_a     = nan_a;
    cls.nan_b     = nan_b;
    cls.snan_a    = snan_a;
    cls.snan_b    = snan_b;
  end

endmodule

// File: rtl/fcmp_pipe.sv
// Pipelined floating-point compare/select: feq, flt, fle, fmin, fmax.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fcmp_pipe_if slave
//              en/op/a/b/tag_in sampled on an edge with en && !stall
//              c/ready/tag_out/nv registered results, nv qualified by ready
//              stall freezes every pipeline register including outputs
// LAT=1 registers the result on the accepting edge; LAT=2 adds a stage that
// holds the classification plus operands, op and tag.
module fcmp_pipe
  import fpu_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int LAT    = 1,
  parameter int NAN_EN = 1,
  parameter int TAG_W  = 5
) (
  input  logic       clk,
  input  logic       rst,
  fcmp_pipe_if.slave bus
);

  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [FP_MAX_W-1:0] CNAN_FULL = canon_nan(EXP_W, MAN_W);
  localparam logic [W-1:0]        CNAN      = CNAN_FULL[W-1:0];

  fcmp_cls_t cls_in;

  fcmp_classify #(
    .EXP_W  (EXP_W),
    .MAN_W  (MAN_W),
    .NAN_EN (NAN_EN)
  ) u_classify (
    .a   (bus.a),
    .b   (bus.b),
    .cls (cls_in)
  );

  // Operands and classification feeding the result mux: straight from the
  // bus for LAT=1, from the stage-1 registers for LAT=2.
  logic             src_valid;
  logic [2:0]       src_op;
  logic [W-1:0]     src_a, src_b;
  logic [TAG_W-1:0] src_tag;
  fcmp_cls_t        src_cls;

  generate
    if (LAT == 2) begin : g_lat2
      logic             s1_valid;
      logic [2:0]       s1_op;
      logic [W-1:0]     s1_a, s1_b;
      logic [TAG_W-1:0] s1_tag;
      fcmp_cls_t        s1_cls;

      always_ff @(posedge clk) begin
        if (rst) begin
          s1_valid <= 1'b0;
          s1_op    <= '0;
          s1_a     <= '0;
          s1_b     <= '0;
          s1_tag   <= '0;
          s1_cls   <= '0;
        end else if (!bus.stall) begin
          s1_valid <= bus.en;
          if (bus.en) begin
            s1_op  <= bus.op;
            s1_a   <= bus.a;
            s1_b   <= bus.b;
            s1_tag <= bus.tag_in;
            s1_cls <= cls_in;
          end
        end
      end

      assign src_valid = s1_valid;
      assign src_op    = s1_op;
      assign src_a     = s1_a;
      assign src_b     = s1_b;
      assign src_tag   = s1_tag;
      assign src_cls   = s1_cls;
    end else begin : g_lat1
      assign src_valid = bus.en;
      assign src_op    = bus.op;
      assign src_a     = bus.a;
      assign src_b     = bus.b;
      assign src_tag   = bus.tag_in;
      assign src_cls   = cls_in;
    end
  endgenerate

  logic         any_nan, any_snan;
  logic         mag_eq, mag_lt;
  logic         is_eq, is_lt, is_le;
  logic [W-1:0] res_c;
  logic         res_nv;

  always_comb begin
    any_nan  = src_cls.nan_a | src_cls.nan_b;
    any_snan = src_cls.snan_a | src_cls.snan_b;
    mag_eq   = src_cls.exp_eq & src_cls.man_eq;
    mag_lt   = src_cls.exp_lt | (src_cls.exp_eq & src_cls.man_le & ~src_cls.man_eq);
    is_eq    = src_cls.both_zero | (~src_cls.sign_xor & mag_eq);

    // Magnitude order flips when both operands are negative.
    if (src_cls.both_zero)
      is_lt = 1'b0;
    else if (src_cls.sign_xor)
      is_lt = src_cls.sign_a;
    else if (src_cls.sign_a)
      is_lt = ~mag_lt & ~mag_eq;
    else
      is_lt = mag_lt;
    is_le = is_lt | is_eq;

    res_c  = '0;
    res_nv = 1'b0;
    case (src_op)
      FOP_FEQ: begin
        res_c[0] = is_eq & ~any_nan;
        res_nv   = any_snan;
      end
      FOP_FLT: begin
        res_c[0] = is_lt & ~any_nan;
        res_nv   = any_nan;
      end
      FOP_FLE: begin
        res_c[0] = is_le & ~any_nan;
        res_nv   = any_nan;
      end
      FOP_FMIN: begin
        res_nv = any_snan;
        if (src_cls.nan_a && src_cls.nan_b) res_c = CNAN;
        else if (src_cls.nan_a)             res_c = src_b;
        else if (src_cls.nan_b)             res_c = src_a;
        else                                res_c = is_le ? src_a : src_b;
      end
      FOP_FMAX: begin
        res_nv = any_snan;
        if (src_cls.nan_a && src_cls.nan_b) res_c = CNAN;
        else if (src_cls.nan_a)             res_c = src_b;
        else if (src_cls.nan_b)             res_c = src_a;
        else                                res_c = is_le ? src_b : src_a;
      end
      default: ;
    endcase
  end

  logic [W-1:0]     c_q;
  logic             ready_q;
  logic [TAG_W-1:0] tag_q;
  logic             nv_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q     <= '0;
      ready_q <= 1'b0;
      tag_q   <= '0;
      nv_q    <= 1'b0;
    end else if (!bus.stall) begin
      ready_q <= src_valid;
      if (src_valid) begin
        c_q   <= res_c;
        tag_q <= src_tag;
        nv_q  <= res_nv;
      end
    end
  end

  assign bus.c       = c_q;
  assign bus.ready   = ready_q;
  assign bus.tag_out = tag_q;
  assign bus.nv      = nv_q;

endmodule

// File: tb/tb_fcmp_pipe.sv
// Bench for fcmp_pipe: single precision at LAT=1 and LAT=2, double at LAT=1.
module tb_fcmp_pipe;
  import fpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fcmp_pipe_if #(.EXP_W(8),  .MAN_W(23), .TAG_W(5)) bus1 ();
  fcmp_pipe_if #(.EXP_W(8),  .MAN_W(23), .TAG_W(5)) bus2 ();
  fcmp_pipe_if #(.EXP_W(11), .MAN_W(52), .TAG_W(5)) busd ();

  fcmp_pipe #(.EXP_W(8),  .MAN_W(23), .LAT(1), .NAN_EN(1), .TAG_W(5)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  fcmp_pipe #(.EXP_W(8),  .MAN_W(23), .LAT(2), .NAN_EN(1), .TAG_W(5)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  fcmp_pipe #(.EXP_W(11), .MAN_W(52), .LAT(1), .NAN_EN(1), .TAG_W(5)) dutd (.clk(clk), .rst(rst), .bus(busd));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
    logic        nv;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Reference: map each operand onto a signed integer key (zero -> 0,
  // otherwise +/- magnitude bits) and compare keys arithmetically.
  function automatic void ref_model(input int ew, input int mw, input logic [2:0] op,
                                    input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] c, output logic nv);
    logic [63:0] emask, mmask, magmask, ea, eb, ma, mb, qnan;
    longint ka, kb;
    logic na, nb, sna, snb;
    emask   = (64'd1 << ew) - 64'd1;
    mmask   = (64'd1 << mw) - 64'd1;
    magmask = (64'd1 << (ew + mw)) - 64'd1;
    ea = (a >> mw) & emask;  eb = (b >> mw) & emask;
    ma = a & mmask;          mb = b & mmask;
    na  = (ea == emask) && (ma != 0);
    nb  = (eb == emask) && (mb != 0);
    sna = na && (((ma >> (mw - 1)) & 64'd1) == 0);
    snb = nb && (((mb >> (mw - 1)) & 64'd1) == 0);
    ka = (ea == 0) ? 0 : (a[ew+mw] ? -longint'(a & magmask) : longint'(a & magmask));
    kb = (eb == 0) ? 0 : (b[ew+mw] ? -longint'(b & magmask) : longint'(b & magmask));
    qnan = (emask << mw) | (64'd1 << (mw - 1));
    c  = 64'd0;
    nv = 1'b0;
    case (op)
      3'd0: begin c = (!(na || nb) && ka == kb) ? 64'd1 : 64'd0; nv = sna || snb; end
      3'd1: begin c = (!(na || nb) && ka <  kb) ? 64'd1 : 64'd0; nv = na || nb; end
      3'd2: begin c = (!(na || nb) && ka <= kb) ? 64'd1 : 64'd0; nv = na || nb; end
      3'd3: begin
        nv = sna || snb;
        if (na && nb) c = qnan; else if (na) c = b; else if (nb) c = a;
        else c = (ka <= kb) ? a : b;
      end
      3'd4: begin
        nv = sna || snb;
        if (na && nb) c = qnan; else if (na) c = b; else if (nb) c = a;
        else c = (ka <= kb) ? b : a;
      end
      default: begin c = 64'd0; nv = 1'b0; end
    endcase
  endfunction

  function automatic logic [63:0] rand_val(input int ew, input int mw, input logic [63:0] other);
    logic [63:0] emask, mmask, fmask, e, m, s;
    emask = (64'd1 << ew) - 64'd1;
    mmask = (64'd1 << mw) - 64'd1;
    fmask = (64'd1 << (ew + mw + 1)) - 64'd1;
    s = 64'($urandom_range(0, 1));
    m = {$urandom, $urandom} & mmask;
    case ($urandom_range(0, 7))
      0: e = {$urandom, $urandom} & emask;
      1: e = 64'd0;
      2: begin e = emask; m = m | (64'd1 << (mw - 1)); end
      3: begin e = emask; m = (m & ~(64'd1 << (mw - 1))) | 64'd1; end
      4: begin e = emask; m = 64'd0; end
      5: return (other ^ ((($urandom_range(0, 1)) == 1) ? (64'd1 << (ew + mw)) : 64'd0)) & fmask;
      default: begin
        e = (emask >> 1) + 64'($urandom_range(0, 2)) - 64'd1;
        if ($urandom_range(0, 1) == 1) m = m & 64'hF;
      end
    endcase
    return ((s << (ew + mw)) | (e << mw) | m) & fmask;
  endfunction

  task automatic drive(input int sel, input logic en, input logic [2:0] op,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] tag, input logic st);
    case (sel)
      0: begin bus1.en = en; bus1.op = op; bus1.a = a[31:0]; bus1.b = b[31:0]; bus1.tag_in = tag; bus1.stall = st; end
      1: begin bus2.en = en; bus2.op = op; bus2.a = a[31:0]; bus2.b = b[31:0]; bus2.tag_in = tag; bus2.stall = st; end
      default: begin busd.en = en; busd.op = op; busd.a = a; busd.b = b; busd.tag_in = tag; busd.stall = st; end
    endcase
  endtask

  task automatic sample(input int sel, output logic [63:0] c, output logic rdy,
                        output logic [4:0] tag, output logic nv);
    case (sel)
      0: begin c = {32'b0, bus1.c}; rdy = bus1.ready; tag = bus1.tag_out; nv = bus1.nv; end
      1: begin c = {32'b0, bus2.c}; rdy = bus2.ready; tag = bus2.tag_out; nv = bus2.nv; end
      default: begin c = busd.c; rdy = busd.ready; tag = busd.tag_out; nv = busd.nv; end
    endcase
  endtask

  // Issue one op and wait (bounded) for its ready; cycles = -1 on timeout.
  task automatic run_one(input int sel, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] tag,
                         output int cycles, output logic [63:0] c, output logic nv,
                         output logic [4:0] tag_o, output logic rdy_after);
    logic rdy, nv2;
    logic [63:0] c2;
    logic [4:0] t2;
    drive(sel, 1'b1, op, a, b, tag, 1'b0);
    @(negedge clk);
    cycles = 1;
    drive(sel, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b0);
    sample(sel, c, rdy, tag_o, nv);
    while (!rdy && cycles < 6) begin
      @(negedge clk);
      cycles++;
      sample(sel, c, rdy, tag_o, nv);
    end
    if (!rdy) cycles = -1;
    @(negedge clk);
    sample(sel, c2, rdy_after, t2, nv2);
  endtask

  // Random stream with a result scoreboard. mode 0: no stall, en always;
  // mode 1: random stall and gaps; mode 2: stall cycles 2..4, en always.
  task automatic run_stream(input int sel, input int n_ops, input int mode, input string name);
    logic [63:0] q_c[$];
    logic        q_nv[$];
    logic [4:0]  q_tag[$];
    int          q_adv[$];
    int issued, got, adv, cyc, lat, ew, mw, exp_adv;
    logic en, st, nv_e, rdy, nv_o, prev_rdy, nv_x;
    logic [2:0] op;
    logic [63:0] a, b, c_e, c_o, prev_c, c_x;
    logic [4:0] tag_o, tag_x;
    lat = (sel == 1) ? 2 : 1;
    ew  = (sel == 2) ? 11 : 8;
    mw  = (sel == 2) ? 52 : 23;
    issued = 0; got = 0; adv = 0; cyc = 0;
    sample(sel, prev_c, prev_rdy, tag_o, nv_o);
    while ((issued < n_ops || got < n_ops) && cyc < n_ops * 4 + 50) begin
      case (mode)
        0:       st = 1'b0;
        1:       st = ($urandom_range(0, 4) == 0);
        default: st = (cyc >= 2 && cyc <= 4);
      endcase
      en = (issued < n_ops) && (mode != 1 || $urandom_range(0, 3) != 0);
      op = ($urandom_range(0, 7) == 7) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      a  = rand_val(ew, mw, {$urandom, $urandom});
      b  = rand_val(ew, mw, a);
      drive(sel, en, op, a, b, 5'(issued), st);
      if (en && !st) begin
        ref_model(ew, mw, op, a, b, c_e, nv_e);
        q_c.push_back(c_e); q_nv.push_back(nv_e); q_tag.push_back(5'(issued));
        q_adv.push_back(adv + 1);
        issued++;
      end
      @(negedge clk);
      cyc++;
      if (!st) adv++;
      sample(sel, c_o, rdy, tag_o, nv_o);
      if (st) begin
        total++;
        if (rdy !== prev_rdy || c_o !== prev_c) begin
          bad++;
          $display("FAIL %s_hold: ready=%b c=%h required ready=%b c=%h", name, rdy, c_o, prev_rdy, prev_c);
        end
      end else if (rdy) begin
        total++;
        if (q_c.size() == 0) begin
          bad++;
          $display("FAIL %s_extra: ready=1 tag=%0d required no result", name, tag_o);
        end else begin
          c_x = q_c.pop_front(); nv_x = q_nv.pop_front(); tag_x = q_tag.pop_front();
          exp_adv = q_adv.pop_front();
          got++;
          if (c_o !== c_x || nv_o !== nv_x || tag_o !== tag_x || adv - exp_adv != lat - 1) begin
            bad++;
            $display("FAIL %s_result: c=%h nv=%b tag=%0d lat=%0d required c=%h nv=%b tag=%0d lat=%0d",
                     name, c_o, nv_o, tag_o, adv - exp_adv + 1, c_x, nv_x, tag_x, lat);
          end
        end
      end
      prev_rdy = rdy;
      prev_c   = c_o;
    end
    total++;
    if (issued != n_ops || got != n_ops) begin
      bad++;
      $display("FAIL %s_count: issued=%0d results=%0d required %0d each", name, issued, got, n_ops);
    end
    drive(sel, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sample(sel, c_o, rdy, tag_o, nv_o);
      total++;
      if (rdy !== 1'b0) begin
        bad++;
        $display("FAIL %s_drain: ready=%b required 0", name, rdy);
      end
    end
  endtask

  task automatic test_reset();
    logic [63:0] c_o;
    logic rdy, nv_o;
    logic [4:0] tag_o;
    rst = 1'b1;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b0);
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) drive(s, 1'b1, FOP_FMAX, 64'h3F800000, 64'h40000000, 5'd7, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sample(s, c_o, rdy, tag_o, nv_o);
      drive(s, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b0);
      total += 4;
      if (c_o   !== 64'd0) begin bad++; $display("FAIL reset_c[%0d]: c=%h required 0", s, c_o); end
      if (rdy   !== 1'b0)  begin bad++; $display("FAIL reset_ready[%0d]: ready=%b required 0", s, rdy); end
      if (tag_o !== 5'd0)  begin bad++; $display("FAIL reset_tag[%0d]: tag=%0d required 0", s, tag_o); end
      if (nv_o  !== 1'b0)  begin bad++; $display("FAIL reset_nv[%0d]: nv=%b required 0", s, nv_o); end
    end
  endtask

  task automatic test_directed();
    vec_t v[15];
    int cycles;
    logic [63:0] c_o;
    logic nv_o, rdy_after;
    logic [4:0] tag_o;
    v[0]  = '{FOP_FLE,  64'h3F800000, 64'h40000000, 64'd1,        1'b0};
    v[1]  = '{FOP_FLE,  64'h40000000, 64'h3F800000, 64'd0,        1'b0};
    v[2]  = '{FOP_FLE,  64'hBF800000, 64'hC0000000, 64'd0,        1'b0};
    v[3]  = '{FOP_FEQ,  64'h00000000, 64'h80000000, 64'd1,        1'b0};
    v[4]  = '{FOP_FLT,  64'h00000000, 64'h80000000, 64'd0,        1'b0};
    v[5]  = '{FOP_FLT,  64'h7FC00000, 64'h3F800000, 64'd0,        1'b1};
    v[6]  = '{FOP_FEQ,  64'h7FC00000, 64'h3F800000, 64'd0,        1'b0};
    v[7]  = '{FOP_FEQ,  64'h7F800001, 64'h3F800000, 64'd0,        1'b1};
    v[8]  = '{FOP_FMIN, 64'h7FC00000, 64'h40000000, 64'h40000000, 1'b0};
    v[9]  = '{FOP_FMAX, 64'h7FC00000, 64'h7F800001, 64'h7FC00000, 1'b1};
    v[10] = '{3'd5,     64'h3F800000, 64'h40000000, 64'd0,        1'b0};
    v[11] = '{FOP_FMAX, 64'hBF800000, 64'h3F800000, 64'h3F800000, 1'b0};
    v[12] = '{FOP_FMIN, 64'h80000000, 64'h00000000, 64'h80000000, 1'b0};
    v[13] = '{FOP_FMAX, 64'h80000000, 64'h00000000, 64'h00000000, 1'b0};
    v[14] = '{FOP_FEQ,  64'h00000001, 64'h00000000, 64'd1,        1'b0};
    for (int i = 0; i < 15; i++) begin
      run_one(0, v[i].op, v[i].a, v[i].b, 5'(i + 1), cycles, c_o, nv_o, tag_o, rdy_after);
      total++;
      if (cycles !== 1 || rdy_after !== 1'b0) begin
        bad++;
        $display("FAIL dir%0d_timing: latency=%0d ready_after=%b required 1 and 0", i, cycles, rdy_after);
      end
      total++;
      if (c_o !== v[i].c || nv_o !== v[i].nv || tag_o !== 5'(i + 1)) begin
        bad++;
        $display("FAIL dir%0d_value: c=%h nv=%b tag=%0d required c=%h nv=%b tag=%0d",
                 i, c_o, nv_o, tag_o, v[i].c, v[i].nv, i + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] ec[4];
    logic        env[4];
    logic [63:0] a, b, c_o;
    logic [2:0]  op;
    logic        rdy, nv_o, exp_r;
    logic [4:0]  tag_o;
    for (int k = 0; k < 8; k++) begin
      if (k < 4) begin
        op = 3'($urandom_range(0, 4));
        a  = rand_val(8, 23, 64'h3F800000);
        b  = rand_val(8, 23, a);
        ref_model(8, 23, op, a, b, ec[k], env[k]);
        drive(1, 1'b1, op, a, b, 5'(k + 1), 1'b0);
      end else begin
        drive(1, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b0);
      end
      @(negedge clk);
      sample(1, c_o, rdy, tag_o, nv_o);
      exp_r = (k + 1 >= 2) && (k + 1 <= 5);
      total++;
      if (rdy !== exp_r) begin
        bad++;
        $display("FAIL b2b_ready%0d: ready=%b required %b", k + 1, rdy, exp_r);
      end
      if (exp_r) begin
        total++;
        if (tag_o !== 5'(k) || c_o !== ec[k-1] || nv_o !== env[k-1]) begin
          bad++;
          $display("FAIL b2b_value%0d: tag=%0d c=%h nv=%b required tag=%0d c=%h nv=%b",
                   k + 1, tag_o, c_o, nv_o, k, ec[k-1], env[k-1]);
        end
      end
    end
  endtask

  task automatic test_stall();
    run_stream(1, 8,   2, "stall_win");
    run_stream(1, 200, 1, "lat2_rand");
    run_stream(0, 200, 1, "lat1_rand");
    run_stream(0, 100, 0, "lat1_full");
  endtask

  task automatic test_reset_flight();
    int cycles;
    logic [63:0] c_o;
    logic nv_o, rdy, rdy_after;
    logic [4:0] tag_o;
    run_one(1, FOP_FMAX, 64'h3F800000, 64'h40000000, 5'd9, cycles, c_o, nv_o, tag_o, rdy_after);
    total++;
    if (cycles !== 2 || c_o !== 64'h40000000 || tag_o !== 5'd9) begin
      bad++;
      $display("FAIL rstf_pre: latency=%0d c=%h tag=%0d required 2 40000000 9", cycles, c_o, tag_o);
    end
    drive(1, 1'b1, FOP_FMAX, 64'h3F800000, 64'h40000000, 5'd3, 1'b0);
    @(negedge clk);
    drive(1, 1'b1, FOP_FMIN, 64'h3F800000, 64'h40000000, 5'd4, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(1, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b0);
    sample(1, c_o, rdy, tag_o, nv_o);
    total++;
    if (c_o !== 64'd0 || rdy !== 1'b0 || tag_o !== 5'd0 || nv_o !== 1'b0) begin
      bad++;
      $display("FAIL rstf_clear: c=%h ready=%b tag=%0d nv=%b required all 0", c_o, rdy, tag_o, nv_o);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sample(1, c_o, rdy, tag_o, nv_o);
      total++;
      if (rdy !== 1'b0) begin
        bad++;
        $display("FAIL rstf_ready%0d: ready=%b required 0", i, rdy);
      end
    end
  endtask

  task automatic test_double();
    int cycles;
    logic [63:0] c_o;
    logic nv_o, rdy_after;
    logic [4:0] tag_o;
    run_one(2, FOP_FMIN, 64'h3FF0000000000000, 64'hBFF0000000000000, 5'd5, cycles, c_o, nv_o, tag_o, rdy_after);
    total++;
    if (cycles !== 1 || c_o !== 64'hBFF0000000000000 || nv_o !== 1'b0) begin
      bad++;
      $display("FAIL dbl_fmin: latency=%0d c=%h nv=%b required 1 bff0000000000000 0", cycles, c_o, nv_o);
    end
    run_one(2, FOP_FMAX, 64'h3FF0000000000000, 64'hBFF0000000000000, 5'd6, cycles, c_o, nv_o, tag_o, rdy_after);
    total++;
    if (cycles !== 1 || c_o !== 64'h3FF0000000000000 || tag_o !== 5'd6) begin
      bad++;
      $display("FAIL dbl_fmax: latency=%0d c=%h tag=%0d required 1 3ff0000000000000 6", cycles, c_o, tag_o);
    end
    run_stream(2, 150, 1, "dbl_rand");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_flight();
    test_double();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fcmp_pipe.md
# fcmp_pipe

Parametrised, pipelined floating-point compare/select unit for the FPU. It supersedes the single-function, one-cycle less-or-equal comparator. One unit executes feq, flt, fle, fmin and fmax on operands of configurable exponent and mantissa width. Latency is selectable (1 or 2 stages), with stall support, a destination-tag pass-through and optional IEEE NaN handling with an invalid flag. It sits in the FPU execute stage beside fadd/fmul, driven by the core's `en`/`ready` convention.

## Interface
- `EXP_W`, 8, exponent width
- `MAN_W`, 23, mantissa width; operand width `W = 1+EXP_W+MAN_W`
- `LAT`, 1, pipeline latency in cycles; legal values 1 or 2
- `NAN_EN`, 1, 1 = IEEE NaN semantics; 0 = NaN encodings compare as ordinary values
- `TAG_W`, 5, width of the pass-through tag
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `en`  in  1  input valid; operands sampled on the edge where `en && !stall`
- `op`  in  3  0=FEQ, 1=FLT, 2=FLE, 3=FMIN, 4=FMAX; 5–7 reserved
- `a`, `b`  in  W  operands
- `tag_in`  in  TAG_W  destination tag
- `stall`  in  1  freeze entire pipeline
- `c`  out  W  result
- `ready`  out  1  result valid, one cycle per accepted op
- `tag_out`  out  TAG_W  tag of the op in `c`
- `nv`  out  1  invalid-operation flag, qualified by `ready`

## Operation
- Zero rule: exponent field 0 means zero. Denormals flush. +0 and −0 compare equal.
- Ordering for non-NaN, non-zero operands:
  - signs differ: `a<b` iff `a` is negative;
  - signs equal: compare exponents; if exponents are equal, compare mantissas;
  - invert the magnitude result when both operands are negative.
- Compare ops: `c = {W-1 zeros, bit}`.
- FMIN: `c = (a<=b) ? a : b`. FMAX: `c = (a<=b) ? b : a`. When operands are equal, FMIN returns `a` and FMAX returns `b`.
- NaN, with `NAN_EN=1`:
  - NaN is exponent all-ones with mantissa ≠ 0. sNaN is a NaN with mantissa MSB = 0.
  - Any NaN operand: FEQ, FLT and FLE return 0.
  - FMIN/FMAX return the non-NaN operand. If both are NaN, return canonical qNaN (0, all-ones exponent, mantissa MSB only).
  - `nv`=1 for FLT/FLE with any NaN. `nv`=1 for FEQ/FMIN/FMAX only if an sNaN is present.
- `NAN_EN=0`: `nv` is tied to 0 and no NaN detection logic is generated.
- Reserved op: `c=0`, `nv=0`, `ready` still asserted.

## Timing
- Reset values: `c=0`, `ready=0`, `tag_out=0`, `nv=0`, all internal valid bits 0.
- `LAT=1`: the result is registered on the accepting edge.
  - An op accepted at edge N is visible after edge N, with `ready`=1 for one cycle.
- `LAT=2`:
  - Stage 1 registers the classification (sign, exponent eq/lt, mantissa le, zero, NaN/sNaN flags) plus `a`, `b`, `op`, `tag`, valid.
  - Stage 2 registers the result. Visible after edge N+1.
- Throughput: one op per cycle. Back-to-back `en` produces back-to-back `ready`.
- `stall`=1: every pipeline register, including the outputs, holds its value. `en` is ignored that cycle. `ready` stays at its held value; the consumer must not double-count while `stall` is high.
- `rst` during operation: all in-flight ops are discarded. No `ready` is produced for them, even if `en` is high in the same cycle.
- `rst` and `stall` both high: reset wins.

## Structure
- Package `fpu_pkg` holds:
  - op localparams `FOP_FEQ..FOP_FMAX`;
  - a canonical-NaN function parametrised by `EXP_W`/`MAN_W`.
- Sub-module `fcmp_classify` (combinational): takes `a`, `b` and produces `sign_a`, `sign_xor`, `exp_eq`, `exp_lt`, `man_le`, `both_zero`, `nan_a/b`, `snan_a/b`.
- `fcmp_pipe` instantiates `fcmp_classify` and owns the stage registers and result muxing. Use generate on `LAT` and `NAN_EN`.

## Test plan
1. Default params, `LAT=1`, FLE, a=0x3F800000 (1.0), b=0x40000000 (2.0) → `c=1`, `ready` high exactly one cycle after the accepting edge. Swap operands → `c=0`.
2. FLE, a=0xBF800000 (−1.0), b=0xC0000000 (−2.0) → 0. FEQ, a=0x00000000, b=0x80000000 → 1. FLT on the same pair → 0.
3. NaN handling:
   - FLT, a=0x7FC00000 (qNaN), b=0x3F800000 → `c=0`, `nv=1`.
   - FEQ on the same pair → `nv=0`.
   - FEQ, a=0x7F800001 (sNaN) → `nv=1`.
   - FMIN, a=qNaN, b=0x40000000 → `c=0x40000000`.
   - FMAX with both operands NaN → `c=0x7FC00000`.
4. `LAT=2`:
   - Issue 4 back-to-back ops with tags 1–4 → four consecutive `ready` pulses starting 2 cycles after the first, with `tag_out` 1,2,3,4 in order.
   - Repeat with `stall` high for 3 cycles mid-stream → no lost or duplicated result and tag order preserved.
5. Pulse `rst` while 2 ops are in flight (`LAT=2`) → no `ready`; all outputs 0 the cycle after reset.
6. `EXP_W=11`, `MAN_W=52` (double): FMIN, a=0x3FF0000000000000 (1.0), b=0xBFF0000000000000 (−1.0) → `c=0xBFF0000000000000`.
